// File: rtl/strobe_sequencer.sv
// strobe_sequencer: round-robin strobe scheduler with per-sequence delay/hold timing and missed-trigger tracking
module strobe_sequencer #(
    parameter int NUM_CHANNELS = 4,
    parameter int NBITS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trigger,
    input  logic                    cfgWe,
    input  logic [1:0]              cfgAddr,
    input  logic [31:0]             cfgData,
    output logic [NUM_CHANNELS-1:0] strobeOut,
    output logic [3:0]              activeChannel,
    output logic                    busy,
    output logic                    missedTrigger,
    output logic [7:0]              missedCount
);
    typedef enum logic [1:0] {IDLE, DELAY, HOLD} state_t;
    state_t                  state_q;
    logic                    trig_q;
    logic                    run_q;
    logic                    missed_q;
    logic [7:0]              mcount_q;
    logic [3:0]              chan_q;
    logic [3:0]              chan_d;
    logic [NUM_CHANNELS-1:0] mask_q;
    logic [NUM_CHANNELS-1:0] strobe_q;
    logic [NUM_CHANNELS-1:0] onehot;
    logic [NBITS-1:0]        delay_q;
    logic [NBITS-1:0]        hold_q;
    logic [NBITS-1:0]        sh_hold_q;
    logic [NBITS-1:0]        cnt_q;
    logic                    trig_edge;
    logic                    in_seq;
    logic                    stop;
    logic                    clr;
    assign trig_edge = trigger & ~trig_q;
    assign in_seq    = state_q != IDLE;
    assign stop      = cfgWe && cfgAddr == 2'd3 && !cfgData[0];
    assign clr       = cfgWe && cfgAddr == 2'd3 && cfgData[1];
    assign onehot    = NUM_CHANNELS'(1) << chan_q;
    // next channel: lowest set mask bit above the current one, else wrap to the lowest set bit
    always_comb begin
        chan_d = chan_q;
        for (int j = NUM_CHANNELS - 1; j >= 0; j--)
            if (mask_q[j]) chan_d = 4'(j);
        for (int j = NUM_CHANNELS - 1; j >= 0; j--)
            if (mask_q[j] && 4'(j) > chan_q) chan_d = 4'(j);
    end
    // config registers, miss tracking and the IDLE/DELAY/HOLD sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            trig_q    <= 1'b0;
            run_q     <= 1'b0;
            missed_q  <= 1'b0;
            mcount_q  <= '0;
            chan_q    <= 4'(NUM_CHANNELS - 1);
            mask_q    <= '0;
            strobe_q  <= '0;
            delay_q   <= '0;
            hold_q    <= '0;
            sh_hold_q <= '0;
            cnt_q     <= '0;
        end else begin
            trig_q <= trigger;
            if (cfgWe && cfgAddr == 2'd0) mask_q <= cfgData[NUM_CHANNELS-1:0];
            if (cfgWe && cfgAddr == 2'd1) delay_q <= cfgData[NBITS-1:0];
            if (cfgWe && cfgAddr == 2'd2) hold_q <= cfgData[NBITS-1:0];
            if (cfgWe && cfgAddr == 2'd3) run_q <= cfgData[0];
            missed_q <= trig_edge && in_seq;
            mcount_q <= clr ? 8'd0 : (trig_edge && in_seq && mcount_q != 8'hff) ? mcount_q + 8'd1 : mcount_q;
            if (stop) begin
                state_q  <= IDLE;
                strobe_q <= '0;
            end else begin
                case (state_q)
                    IDLE: if (trig_edge && run_q && |mask_q) begin
                        state_q   <= DELAY;
                        cnt_q     <= delay_q;
                        sh_hold_q <= hold_q;
                        chan_q    <= chan_d;
                    end
                    DELAY: if (cnt_q != '0) begin
                        cnt_q <= cnt_q - NBITS'(1);
                    end else begin
                        // the first HOLD cycle already drives the strobe, so load hold-1
                        state_q  <= HOLD;
                        cnt_q    <= (sh_hold_q == '0) ? '0 : sh_hold_q - NBITS'(1);
                        strobe_q <= (sh_hold_q == '0) ? '0 : onehot;
                    end
                    HOLD: if (cnt_q != '0) begin
                        cnt_q <= cnt_q - NBITS'(1);
                    end else begin
                        state_q  <= IDLE;
                        strobe_q <= '0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign strobeOut     = strobe_q;
    assign activeChannel = chan_q;
    assign busy          = in_seq;
    assign missedTrigger = missed_q;
    assign missedCount   = mcount_q;
endmodule

// File: tb/tb_strobe_sequencer.sv
// tb_strobe_sequencer: directed checks of strobe timing, round-robin selection, miss tracking, abort and reset
module tb_strobe_sequencer;
    logic        clk;
    logic        reset;
    logic        trigger;
    logic        cfgWe;
    logic [1:0]  cfgAddr;
    logic [31:0] cfgData;
    logic [3:0]  strobeOut;
    logic [3:0]  activeChannel;
    logic        busy;
    logic        missedTrigger;
    logic [7:0]  missedCount;
    int total = 0;
    int bad = 0;

    strobe_sequencer #(.NUM_CHANNELS(4), .NBITS(16)) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .cfgWe(cfgWe), .cfgAddr(cfgAddr),
        .cfgData(cfgData), .strobeOut(strobeOut), .activeChannel(activeChannel), .busy(busy),
        .missedTrigger(missedTrigger), .missedCount(missedCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfgWe = 1'b1;
        cfgAddr = a;
        cfgData = d;
        tick();
        cfgWe = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // one-cycle trigger; returns in cycle t+1
    task automatic pulse_trig;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    // full sequence: strobe on cycles t+2+d..t+1+d+h, busy t+1..t+1+d+max(h,1)
    task automatic seq(input int d, input int h, input int ch, input string tag);
        int hl;
        hl = (h == 0) ? 1 : h;
        pulse_trig();
        chk({tag, " chan"}, activeChannel, ch);
        for (int k = 1; k <= d + hl + 2; k++) begin
            chk({tag, " strobe"}, strobeOut, (k >= d + 2 && k <= d + 1 + h) ? (32'd1 << ch) : 32'd0);
            chk({tag, " busy"}, busy, k <= d + 1 + hl);
            tick();
        end
    endtask

    initial begin
        trigger = 1'b0;
        cfgWe = 1'b0;
        cfgAddr = 2'd0;
        cfgData = 32'd0;
        do_reset();
        chk("rst strobe", strobeOut, 0);
        chk("rst busy", busy, 0);
        chk("rst missed", missedTrigger, 0);
        chk("rst count", missedCount, 0);
        chk("rst chan", activeChannel, 3);
        pulse_trig();
        chk("no run busy", busy, 0);
        // 1: round robin over mask 0101
        wr(0, 32'h5);
        wr(1, 3);
        wr(2, 2);
        wr(3, 1);
        seq(3, 2, 0, "t1a");
        seq(3, 2, 2, "t1b");
        seq(3, 2, 0, "t1c");
        // 2: single channel, D=0 H=1
        wr(0, 32'h8);
        wr(1, 0);
        wr(2, 1);
        seq(0, 1, 3, "t2a");
        seq(0, 1, 3, "t2b");
        seq(0, 1, 3, "t2c");
        // 3: edge while busy is ignored and counted
        wr(0, 32'h1);
        wr(1, 10);
        wr(2, 5);
        pulse_trig();
        tick();
        tick();
        tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("t3 missed pulse", missedTrigger, 1);
        chk("t3 count", missedCount, 1);
        for (int k = 6; k <= 18; k++) begin
            tick();
            chk("t3 strobe", strobeOut, (k >= 12 && k <= 16) ? 1 : 0);
            chk("t3 missed low", missedTrigger, 0);
        end
        chk("t3 count hold", missedCount, 1);
        wr(3, 3);
        chk("t3 clear", missedCount, 0);
        // edge on the last HOLD cycle is also a miss
        wr(1, 0);
        wr(2, 1);
        pulse_trig();
        tick();
        chk("t3 last hold strobe", strobeOut, 1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("t3 late missed", missedTrigger, 1);
        chk("t3 late busy", busy, 0);
        chk("t3 late count", missedCount, 1);
        wr(3, 3);
        chk("t3 clear2", missedCount, 0);
        // 4: H=0 gives no pulse but advances
        do_reset();
        wr(0, 32'h3);
        wr(3, 1);
        seq(0, 0, 0, "t4a");
        seq(0, 0, 1, "t4b");
        // 5: run=0 mid-HOLD aborts
        wr(0, 32'h1);
        wr(2, 5);
        pulse_trig();
        tick();
        tick();
        chk("t5 strobe on", strobeOut, 1);
        wr(3, 0);
        chk("t5 strobe off", strobeOut, 0);
        chk("t5 busy off", busy, 0);
        chk("t5 chan kept", activeChannel, 0);
        pulse_trig();
        chk("t5 stopped busy", busy, 0);
        chk("t5 stopped miss", missedTrigger, 0);
        tick();
        tick();
        chk("t5 stopped strobe", strobeOut, 0);
        wr(3, 1);
        seq(0, 5, 0, "t5 rerun");
        // 6: reset mid-DELAY, then delay write mid-DELAY
        wr(1, 5);
        wr(2, 2);
        pulse_trig();
        tick();
        chk("t6 busy pre", busy, 1);
        do_reset();
        chk("t6 rst busy", busy, 0);
        chk("t6 rst chan", activeChannel, 3);
        chk("t6 rst strobe", strobeOut, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("t6 abandoned", strobeOut, 0);
        end
        wr(0, 32'h2);
        wr(1, 4);
        wr(2, 2);
        wr(3, 1);
        pulse_trig();
        wr(1, 100);
        for (int k = 2; k <= 9; k++) begin
            chk("t6 shadow strobe", strobeOut, (k == 6 || k == 7) ? 2 : 0);
            chk("t6 shadow busy", busy, k <= 7);
            tick();
        end
        seq(100, 2, 1, "t6 new delay");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
